nibble_add_seq: RTL and testbench

- Sequencing controller for the shared 4-bit full-adder slice (in_1/in_2/in_3 -> out_1/out_2).
- Performs a W = 4*NIBBLES bit addition by feeding the slice one nibble per cycle, least significant nibble first, chaining carry through a register.
- Sits between a requester (valid/ready command) and one external adder instance, which is wired to the add_* ports.

---
 rtl/nibble_add_seq_if.sv | 42 ++++
 rtl/nibble_add_seq.sv | 110 +++++++++++
 tb/tb_nibble_add_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nibble_add_seq_if.sv
// Bus bundle for nibble_add_seq: requester command, response and the
// external 4-bit adder slice wiring. The optional overflow flag is present
// only when NIBBLE_ADD_OVF_EN is defined.
interface nibble_add_seq_if #(
  parameter int NIBBLES = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic [4*NIBBLES-1:0]   req_a;
  logic [4*NIBBLES-1:0]   req_b;
  logic                   req_cin;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [4*NIBBLES-1:0]   rsp_sum;
  logic                   rsp_cout;
`ifdef NIBBLE_ADD_OVF_EN
  logic                   rsp_ovf;
`endif
  logic [3:0]             add_in_1;
  logic [3:0]             add_in_2;
  logic                   add_in_3;
  logic [3:0]             add_out_1;
  logic                   add_out_2;

  // Controller side
  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready, add_out_1, add_out_2,
`ifdef NIBBLE_ADD_OVF_EN
    output rsp_ovf,
`endif
    output req_ready, rsp_valid, rsp_sum, rsp_cout, add_in_1, add_in_2, add_in_3
  );

  // Requester / adder-slice side
  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready, add_out_1, add_out_2,
`ifdef NIBBLE_ADD_OVF_EN
    input  rsp_ovf,
`endif
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, add_in_1, add_in_2, add_in_3
  );
endinterface

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: sequences a 4*NIBBLES-bit addition through one external
// 4-bit full-adder slice, least significant nibble first, carry chained
// through a register. Optional macro NIBBLE_ADD_OVF_EN adds rsp_ovf, the
// signed two's-complement overflow flag. The interface instance must be
// built with the same NIBBLES value as this module.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic              sim_clk,
  input  logic              reset,
  nibble_add_seq_if.slave   bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    sum_reg;
`ifdef NIBBLE_ADD_OVF_EN
  logic            ovf_reg;
`endif

  // State register
  always_ff @(posedge sim_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and output decode; adder slice sees zeros outside RUN
  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.add_in_1  = '0;
    bus.add_in_2  = '0;
    bus.add_in_3  = 1'b0;
    bus.rsp_sum   = sum_reg;
    bus.rsp_cout  = carry;
`ifdef NIBBLE_ADD_OVF_EN
    bus.rsp_ovf   = ovf_reg;
`endif
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_next = RUN;
      end
      RUN: begin
        bus.add_in_1 = a_reg[{idx, 2'b00} +: 4];
        bus.add_in_2 = b_reg[{idx, 2'b00} +: 4];
        bus.add_in_3 = carry;
        if (idx == LAST) state_next = DONE;
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-nibble sum accumulation and carry chaining
  always_ff @(posedge sim_clk or posedge reset) begin
    if (reset) begin
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
`ifdef NIBBLE_ADD_OVF_EN
      ovf_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_reg   <= bus.req_a;
            b_reg   <= bus.req_b;
            carry   <= bus.req_cin;
            idx     <= '0;
            sum_reg <= '0;
`ifdef NIBBLE_ADD_OVF_EN
            ovf_reg <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum_reg[{idx, 2'b00} +: 4] <= bus.add_out_1;
          carry                      <= bus.add_out_2;
          if (idx == LAST) begin
`ifdef NIBBLE_ADD_OVF_EN
            // Final sum MSB is add_out_1[3] on this edge, not yet in sum_reg
            ovf_reg <= (a_reg[W-1] == b_reg[W-1]) &&
                       (bus.add_out_1[3] != a_reg[W-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed, table-driven bench for nibble_add_seq with NIBBLES=4 and a
// behavioural 4-bit adder slice on the add_* wires.
module tb_nibble_add_seq;
  logic sim_clk = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  nibble_add_seq_if #(.NIBBLES(4)) bus ();

  nibble_add_seq #(.NIBBLES(4)) dut (
    .sim_clk (sim_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sim_clk = ~sim_clk;

  assign {bus.add_out_2, bus.add_out_1} = bus.add_in_1 + bus.add_in_2 + 5'(bus.add_in_3);

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  in3;   // carry into nibble i at bit i
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after acceptance (RUN, idx 0)
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
    bus.req_valid = 1'b1;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(negedge sim_clk);
    bus.req_valid = 1'b0;
    chk("req_ready_run", 32'(bus.req_ready), 32'd0);
  endtask

  // Samples the four RUN cycles, then checks the result in the first DONE cycle
  task automatic collect(input vec_t v);
    logic [15:0] in1_log;
    logic [3:0]  in3_log;
    in1_log = '0;
    in3_log = '0;
    for (int i = 0; i < 4; i++) begin
      in1_log[4*i +: 4] = bus.add_in_1;
      in3_log[i]        = bus.add_in_3;
      chk("rsp_valid_run", 32'(bus.rsp_valid), 32'd0);
      @(negedge sim_clk);
    end
    chk("add_in_1_seq", 32'(in1_log), 32'(v.a));
    chk("add_in_3_seq", 32'(in3_log), 32'(v.in3));
    chk("rsp_valid_done", 32'(bus.rsp_valid), 32'd1);
    chk("req_ready_done", 32'(bus.req_ready), 32'd0);
    chk("rsp_sum", 32'(bus.rsp_sum), 32'(v.sum));
    chk("rsp_cout", 32'(bus.rsp_cout), 32'(v.cout));
    chk("add_in_1_done", 32'(bus.add_in_1), 32'd0);
`ifdef NIBBLE_ADD_OVF_EN
    chk("rsp_ovf", 32'(bus.rsp_ovf), 32'(v.ovf));
`endif
  endtask

  // Accept the response; result must stay visible in IDLE
  task automatic release_rsp(input vec_t v);
    bus.rsp_ready = 1'b1;
    @(negedge sim_clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
    chk("req_ready_after", 32'(bus.req_ready), 32'd1);
    chk("rsp_sum_held", 32'(bus.rsp_sum), 32'(v.sum));
    chk("add_in_idle", 32'({bus.add_in_1, bus.add_in_2, bus.add_in_3}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //            a         b         cin   sum       cout  ovf   in3
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 4'h6};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'hE};
    vecs[2] = '{16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, 4'h1};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'hE};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'h0};
    vecs[5] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 4'hE};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4'hF};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'h0};

    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset state
    @(negedge sim_clk);
    @(negedge sim_clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    chk("rst_rsp_cout", 32'(bus.rsp_cout), 32'd0);
    chk("rst_add_in", 32'({bus.add_in_1, bus.add_in_2, bus.add_in_3}), 32'd0);
    reset = 1'b0;
    @(negedge sim_clk);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin);
      collect(vecs[i]);
      release_rsp(vecs[i]);
    end

    // Backpressure: new command held throughout DONE must not be taken
    issue(vecs[2].a, vecs[2].b, vecs[2].cin);
    collect(vecs[2]);
    bus.req_a     = 16'h0003;
    bus.req_b     = 16'h0004;
    bus.req_cin   = 1'b0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sim_clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_sum", 32'(bus.rsp_sum), 32'h2346);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge sim_clk);
    bus.rsp_ready = 1'b0;
    chk("bp_idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge sim_clk);
    bus.req_valid = 1'b0;
    chk("bp_accepted", 32'(bus.req_ready), 32'd0);
    v = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 4'h0};
    collect(v);
    release_rsp(v);

    // Reset two cycles into RUN aborts with no partial result
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    @(negedge sim_clk);
    @(negedge sim_clk);
    reset = 1'b1;
    #1;
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    chk("abort_rsp_cout", 32'(bus.rsp_cout), 32'd0);
    chk("abort_add_in", 32'({bus.add_in_1, bus.add_in_2, bus.add_in_3}), 32'd0);
    @(negedge sim_clk);
    reset = 1'b0;
    @(negedge sim_clk);
    issue(16'h0003, 16'h0004, 1'b0);
    collect(v);
    release_rsp(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
